// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, ALU ops,
// opcodes/funcs, decode classes, datapath select codes and the control word.
package mc_ctrl_pkg;

   localparam int unsigned ST_W    = 3;
   localparam int unsigned ALUOP_W = 4;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned FN_W    = 6;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned CLS_W   = 4;

   typedef enum logic [ST_W-1:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0000;
   localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALUOP_W-1:0] ALU_XOR = 4'b0011;
   localparam logic [ALUOP_W-1:0] ALU_NOR = 4'b0100;
   localparam logic [ALUOP_W-1:0] ALU_SRL = 4'b0101;
   localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALUOP_W-1:0] ALU_SLT = 4'b0111;
   localparam logic [ALUOP_W-1:0] ALU_SLL = 4'b1000;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

   localparam logic [FN_W-1:0] FN_SLL = 6'h00;
   localparam logic [FN_W-1:0] FN_SRL = 6'h02;
   localparam logic [FN_W-1:0] FN_JR  = 6'h08;
   localparam logic [FN_W-1:0] FN_ADD = 6'h20;
   localparam logic [FN_W-1:0] FN_SUB = 6'h22;
   localparam logic [FN_W-1:0] FN_AND = 6'h24;
   localparam logic [FN_W-1:0] FN_OR  = 6'h25;
   localparam logic [FN_W-1:0] FN_XOR = 6'h26;
   localparam logic [FN_W-1:0] FN_NOR = 6'h27;
   localparam logic [FN_W-1:0] FN_SLT = 6'h2a;

   typedef enum logic [CLS_W-1:0] {
      CL_RTYPE = 4'd0,
      CL_SHIFT = 4'd1,
      CL_JR    = 4'd2,
      CL_LW    = 4'd3,
      CL_SW    = 4'd4,
      CL_ADDI  = 4'd5,
      CL_ORI   = 4'd6,
      CL_LUI   = 4'd7,
      CL_BEQ   = 4'd8,
      CL_BNE   = 4'd9,
      CL_J     = 4'd10,
      CL_JAL   = 4'd11
   } iclass_t;

   localparam logic [SEL_W-1:0] PCSRC_SEQ = 2'b00;
   localparam logic [SEL_W-1:0] PCSRC_BR  = 2'b01;
   localparam logic [SEL_W-1:0] PCSRC_JR  = 2'b10;
   localparam logic [SEL_W-1:0] PCSRC_JMP = 2'b11;

   localparam logic [SEL_W-1:0] REGDST_RD = 2'b00;
   localparam logic [SEL_W-1:0] REGDST_RT = 2'b01;
   localparam logic [SEL_W-1:0] REGDST_RA = 2'b10;

   localparam logic [SEL_W-1:0] M2R_ALU = 2'b00;
   localparam logic [SEL_W-1:0] M2R_MDR = 2'b01;
   localparam logic [SEL_W-1:0] M2R_PC  = 2'b10;
   localparam logic [SEL_W-1:0] M2R_LUI = 2'b11;

   localparam logic [SEL_W-1:0] ASRC_PC    = 2'b00;
   localparam logic [SEL_W-1:0] ASRC_RS    = 2'b01;
   localparam logic [SEL_W-1:0] ASRC_SHAMT = 2'b10;

   localparam logic [SEL_W-1:0] BSRC_RT   = 2'b00;
   localparam logic [SEL_W-1:0] BSRC_FOUR = 2'b01;
   localparam logic [SEL_W-1:0] BSRC_SEXT = 2'b10;
   localparam logic [SEL_W-1:0] BSRC_ZEXT = 2'b11;

   // Full set of datapath strobes and selects driven each cycle
   typedef struct packed {
      logic               pc_write;
      logic [SEL_W-1:0]   pc_src;
      logic               ir_write;
      logic               iord;
      logic               mem_read;
      logic               mem_write;
      logic [SEL_W-1:0]   reg_dst;
      logic [SEL_W-1:0]   mem2reg;
      logic               reg_write;
      logic [SEL_W-1:0]   alu_src_a;
      logic [SEL_W-1:0]   alu_src_b;
      logic [ALUOP_W-1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/func -> instruction class, ALU op, legality.
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [OP_W-1:0]    opcode,
   input  logic [FN_W-1:0]    func,
   output iclass_t            cls_c,
   output logic [ALUOP_W-1:0] alu_op_c,
   output logic               legal_c
);

   // Classify the instruction; anything not listed is illegal
   always_comb begin
      cls_c    = CL_RTYPE;
      alu_op_c = ALU_ADD;
      legal_c  = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            case (func)
               FN_ADD:  alu_op_c = ALU_ADD;
               FN_SUB:  alu_op_c = ALU_SUB;
               FN_AND:  alu_op_c = ALU_AND;
               FN_OR:   alu_op_c = ALU_OR;
               FN_XOR:  alu_op_c = ALU_XOR;
               FN_NOR:  alu_op_c = ALU_NOR;
               FN_SLT:  alu_op_c = ALU_SLT;
               FN_SLL:  begin cls_c = CL_SHIFT; alu_op_c = ALU_SLL; end
               FN_SRL:  begin cls_c = CL_SHIFT; alu_op_c = ALU_SRL; end
               FN_JR:   cls_c = CL_JR;
               default: legal_c = 1'b0;
            endcase
         end
         OP_LW:   cls_c = CL_LW;
         OP_SW:   cls_c = CL_SW;
         OP_ADDI: cls_c = CL_ADDI;
         OP_ORI:  begin cls_c = CL_ORI; alu_op_c = ALU_OR;  end
         OP_LUI:  cls_c = CL_LUI;
         OP_BEQ:  begin cls_c = CL_BEQ; alu_op_c = ALU_SUB; end
         OP_BNE:  begin cls_c = CL_BNE; alu_op_c = ALU_SUB; end
         OP_J:    cls_c = CL_J;
         OP_JAL:  cls_c = CL_JAL;
         default: legal_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle MIPS datapath (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Optional MEM_WAIT_EN: FETCH and MEM stall until mem_ready; otherwise mem_ready is ignored.
// Control outputs are decoded from the state and latched class; branch pc_write and
// the stall handshake depend on zero/mem_ready within the same cycle by design.
module multicycle_controller
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned STATE_W = 3
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [OP_W-1:0]    opcode,
   input  logic [FN_W-1:0]    func,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic [SEL_W-1:0]   pc_src,
   output logic               ir_write,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic [SEL_W-1:0]   reg_dst,
   output logic [SEL_W-1:0]   mem2reg,
   output logic               reg_write,
   output logic [SEL_W-1:0]   alu_src_a,
   output logic [SEL_W-1:0]   alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [STATE_W-1:0] state,
   output logic               illegal
);

   state_t             state_q;
   state_t             next_state;
   iclass_t            cls_q;
   logic [ALUOP_W-1:0] alu_op_q;
   logic               illegal_q;
   iclass_t            cls_c;
   logic [ALUOP_W-1:0] alu_op_c;
   logic               legal_c;
   logic               mem_ok;
   ctrl_t              ctl_c;

`ifdef MEM_WAIT_EN
   assign mem_ok = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_ok           = 1'b1;
`endif

   mc_decode u_decode (
      .opcode   (opcode),
      .func     (func),
      .cls_c    (cls_c),
      .alu_op_c (alu_op_c),
      .legal_c  (legal_c)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= next_state;
   end

   // Hold the decode result for the rest of the instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cls_q    <= CL_RTYPE;
         alu_op_q <= ALU_AND;
      end else if (state_q == DECODE) begin
         cls_q    <= cls_c;
         alu_op_q <= alu_op_c;
      end
   end

   // Sticky illegal flag, raised on entry to TRAP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  illegal_q <= 1'b0;
      else if (next_state == TRAP) illegal_q <= 1'b1;
   end

   // Next-state and control word per state
   always_comb begin
      next_state = state_q;
      ctl_c      = '0;
      case (state_q)
         FETCH: begin
            ctl_c.iord      = 1'b0;
            ctl_c.mem_read  = 1'b1;
            ctl_c.alu_src_a = ASRC_PC;
            ctl_c.alu_src_b = BSRC_FOUR;
            ctl_c.alu_op    = ALU_ADD;
            ctl_c.pc_src    = PCSRC_SEQ;
            if (mem_ok) begin
               ctl_c.ir_write = 1'b1;
               ctl_c.pc_write = 1'b1;
               next_state     = DECODE;
            end
         end
         DECODE: begin
            ctl_c.alu_src_a = ASRC_PC;
            ctl_c.alu_src_b = BSRC_ZEXT;
            ctl_c.alu_op    = ALU_ADD;
            next_state      = legal_c ? EXEC : TRAP;
         end
         EXEC: begin
            case (cls_q)
               CL_RTYPE: begin
                  ctl_c.alu_src_a = ASRC_RS;
                  ctl_c.alu_src_b = BSRC_RT;
                  ctl_c.alu_op    = alu_op_q;
                  next_state      = WB;
               end
               CL_SHIFT: begin
                  ctl_c.alu_src_a = ASRC_SHAMT;
                  ctl_c.alu_src_b = BSRC_RT;
                  ctl_c.alu_op    = alu_op_q;
                  next_state      = WB;
               end
               CL_LW, CL_SW, CL_ADDI: begin
                  ctl_c.alu_src_a = ASRC_RS;
                  ctl_c.alu_src_b = BSRC_SEXT;
                  ctl_c.alu_op    = ALU_ADD;
                  next_state      = (cls_q == CL_ADDI) ? WB : MEM;
               end
               CL_ORI: begin
                  ctl_c.alu_src_a = ASRC_RS;
                  ctl_c.alu_src_b = BSRC_ZEXT;
                  ctl_c.alu_op    = ALU_OR;
                  next_state      = WB;
               end
               CL_LUI: next_state = WB;
               CL_BEQ, CL_BNE: begin
                  ctl_c.alu_src_a = ASRC_RS;
                  ctl_c.alu_src_b = BSRC_RT;
                  ctl_c.alu_op    = ALU_SUB;
                  ctl_c.pc_src    = PCSRC_BR;
                  ctl_c.pc_write  = (cls_q == CL_BEQ) ? zero : ~zero;
                  next_state      = FETCH;
               end
               CL_J: begin
                  ctl_c.pc_src   = PCSRC_JMP;
                  ctl_c.pc_write = 1'b1;
                  next_state     = FETCH;
               end
               CL_JAL: begin
                  // PC still holds PC+4 this cycle, so it is the link value
                  ctl_c.pc_src    = PCSRC_JMP;
                  ctl_c.pc_write  = 1'b1;
                  ctl_c.reg_dst   = REGDST_RA;
                  ctl_c.mem2reg   = M2R_PC;
                  ctl_c.reg_write = 1'b1;
                  next_state      = FETCH;
               end
               CL_JR: begin
                  ctl_c.pc_src   = PCSRC_JR;
                  ctl_c.pc_write = 1'b1;
                  next_state     = FETCH;
               end
               default: next_state = FETCH;
            endcase
         end
         MEM: begin
            ctl_c.iord = 1'b1;
            if (cls_q == CL_SW) ctl_c.mem_write = 1'b1;
            else                ctl_c.mem_read  = 1'b1;
            if (mem_ok) next_state = (cls_q == CL_SW) ? FETCH : WB;
         end
         WB: begin
            ctl_c.reg_write = 1'b1;
            ctl_c.reg_dst   = (cls_q == CL_RTYPE || cls_q == CL_SHIFT) ? REGDST_RD : REGDST_RT;
            if (cls_q == CL_LW)       ctl_c.mem2reg = M2R_MDR;
            else if (cls_q == CL_LUI) ctl_c.mem2reg = M2R_LUI;
            else                      ctl_c.mem2reg = M2R_ALU;
            next_state = FETCH;
         end
         TRAP: next_state = TRAP;
         default: next_state = FETCH;
      endcase
      // Reset holds every strobe and select low regardless of state
      if (!rst_n) ctl_c = '0;
   end

   assign pc_write  = ctl_c.pc_write;
   assign pc_src    = ctl_c.pc_src;
   assign ir_write  = ctl_c.ir_write;
   assign iord      = ctl_c.iord;
   assign mem_read  = ctl_c.mem_read;
   assign mem_write = ctl_c.mem_write;
   assign reg_dst   = ctl_c.reg_dst;
   assign mem2reg   = ctl_c.mem2reg;
   assign reg_write = ctl_c.reg_write;
   assign alu_src_a = ctl_c.alu_src_a;
   assign alu_src_b = ctl_c.alu_src_b;
   assign alu_op    = ctl_c.alu_op;
   assign state     = STATE_W'(state_q);
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; expected control words are hand-written per state.
module tb_multicycle_controller;

   localparam logic [2:0] S_F = 3'd0;
   localparam logic [2:0] S_D = 3'd1;
   localparam logic [2:0] S_E = 3'd2;
   localparam logic [2:0] S_M = 3'd3;
   localparam logic [2:0] S_W = 3'd4;
   localparam logic [2:0] S_T = 3'd5;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] func;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, illegal;
   logic [1:0] pc_src, reg_dst, mem2reg, alu_src_a, alu_src_b;
   logic [3:0] alu_op;
   logic [2:0] state;
   logic [19:0] ctrl_now;

   int checks = 0;
   int errors = 0;

   multicycle_controller #(.STATE_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode),
      .func      (func),
      .zero      (zero),
      .mem_ready (mem_ready),
      .pc_write  (pc_write),
      .pc_src    (pc_src),
      .ir_write  (ir_write),
      .iord      (iord),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .reg_dst   (reg_dst),
      .mem2reg   (mem2reg),
      .reg_write (reg_write),
      .alu_src_a (alu_src_a),
      .alu_src_b (alu_src_b),
      .alu_op    (alu_op),
      .state     (state),
      .illegal   (illegal)
   );

   assign ctrl_now = {pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                      reg_dst, mem2reg, reg_write, alu_src_a, alu_src_b, alu_op};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack a control word in port order
   function automatic logic [19:0] cw(int pw, int ps, int irw, int io, int mr, int mw,
                                      int rd, int m2r, int rw, int a, int b, int alu);
      return {1'(pw), 2'(ps), 1'(irw), 1'(io), 1'(mr), 1'(mw),
              2'(rd), 2'(m2r), 1'(rw), 2'(a), 2'(b), 4'(alu)};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Check one cycle (called at a negedge), then advance to the next negedge
   task automatic cyc(input string tag, input logic [2:0] st, input logic [19:0] c, input logic ill);
      #1;
      check({tag, " state"},   32'(state),    32'(st));
      check({tag, " ctrl"},    32'(ctrl_now), 32'(c));
      check({tag, " illegal"}, 32'(illegal),  32'(ill));
      @(negedge clk);
   endtask

   task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
      opcode = op;
      func   = fn;
      zero   = z;
   endtask

   logic [19:0] cw_f, cw_d, cw_wb_rd, cw_wb_rt;

   initial begin
      cw_f     = cw(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 2);
      cw_d     = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2);
      cw_wb_rd = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      cw_wb_rt = cw(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);

      rst_n = 1'b0; mem_ready = 1'b1;
      instr(6'h00, 6'h20, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      check("reset state",   32'(state),    32'(S_F));
      check("reset ctrl",    32'(ctrl_now), 32'd0);
      check("reset illegal", 32'(illegal),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // add
      instr(6'h00, 6'h20, 1'b0);
      cyc("add F", S_F, cw_f, 0);
      cyc("add D", S_D, cw_d, 0);
      cyc("add E", S_E, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2), 0);
      cyc("add W", S_W, cw_wb_rd, 0);
      // sub
      instr(6'h00, 6'h22, 1'b0);
      cyc("sub F", S_F, cw_f, 0);
      cyc("sub D", S_D, cw_d, 0);
      cyc("sub E", S_E, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6), 0);
      cyc("sub W", S_W, cw_wb_rd, 0);
      // sll
      instr(6'h00, 6'h00, 1'b0);
      cyc("sll F", S_F, cw_f, 0);
      cyc("sll D", S_D, cw_d, 0);
      cyc("sll E", S_E, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 8), 0);
      cyc("sll W", S_W, cw_wb_rd, 0);
      // slt
      instr(6'h00, 6'h2a, 1'b0);
      cyc("slt F", S_F, cw_f, 0);
      cyc("slt D", S_D, cw_d, 0);
      cyc("slt E", S_E, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7), 0);
      cyc("slt W", S_W, cw_wb_rd, 0);
      // lw
      instr(6'h23, 6'h00, 1'b0);
      cyc("lw F", S_F, cw_f, 0);
      cyc("lw D", S_D, cw_d, 0);
      cyc("lw E", S_E, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2), 0);
      cyc("lw M", S_M, cw(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0);
      cyc("lw W", S_W, cw(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0), 0);
      // sw
      instr(6'h2b, 6'h00, 1'b0);
      cyc("sw F", S_F, cw_f, 0);
      cyc("sw D", S_D, cw_d, 0);
      cyc("sw E", S_E, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2), 0);
      cyc("sw M", S_M, cw(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 0);
      // addi
      instr(6'h08, 6'h00, 1'b0);
      cyc("addi F", S_F, cw_f, 0);
      cyc("addi D", S_D, cw_d, 0);
      cyc("addi E", S_E, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2), 0);
      cyc("addi W", S_W, cw_wb_rt, 0);
      // ori
      instr(6'h0d, 6'h00, 1'b0);
      cyc("ori F", S_F, cw_f, 0);
      cyc("ori D", S_D, cw_d, 0);
      cyc("ori E", S_E, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1), 0);
      cyc("ori W", S_W, cw_wb_rt, 0);
      // lui
      instr(6'h0f, 6'h00, 1'b0);
      cyc("lui F", S_F, cw_f, 0);
      cyc("lui D", S_D, cw_d, 0);
      cyc("lui E", S_E, 20'd0, 0);
      cyc("lui W", S_W, cw(0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0), 0);
      // beq taken / not taken
      instr(6'h04, 6'h00, 1'b1);
      cyc("beq1 F", S_F, cw_f, 0);
      cyc("beq1 D", S_D, cw_d, 0);
      cyc("beq1 E", S_E, cw(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6), 0);
      instr(6'h04, 6'h00, 1'b0);
      cyc("beq0 F", S_F, cw_f, 0);
      cyc("beq0 D", S_D, cw_d, 0);
      cyc("beq0 E", S_E, cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6), 0);
      // bne with zero=1 / zero=0
      instr(6'h05, 6'h00, 1'b1);
      cyc("bne1 F", S_F, cw_f, 0);
      cyc("bne1 D", S_D, cw_d, 0);
      cyc("bne1 E", S_E, cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6), 0);
      instr(6'h05, 6'h00, 1'b0);
      cyc("bne0 F", S_F, cw_f, 0);
      cyc("bne0 D", S_D, cw_d, 0);
      cyc("bne0 E", S_E, cw(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6), 0);
      // j
      instr(6'h02, 6'h00, 1'b0);
      cyc("j F", S_F, cw_f, 0);
      cyc("j D", S_D, cw_d, 0);
      cyc("j E", S_E, cw(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
      // jal
      instr(6'h03, 6'h00, 1'b0);
      cyc("jal F", S_F, cw_f, 0);
      cyc("jal D", S_D, cw_d, 0);
      cyc("jal E", S_E, cw(1, 3, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0), 0);
      // jr
      instr(6'h00, 6'h08, 1'b0);
      cyc("jr F", S_F, cw_f, 0);
      cyc("jr D", S_D, cw_d, 0);
      cyc("jr E", S_E, cw(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);

      // Unknown opcode traps; held for 10 cycles, then reset pulse recovers
      instr(6'h3f, 6'h00, 1'b0);
      cyc("badop F", S_F, cw_f, 0);
      cyc("badop D", S_D, cw_d, 0);
      for (int i = 0; i < 10; i++) cyc("badop T", S_T, 20'd0, 1);
      rst_n = 1'b0;
      cyc("trap rst", S_F, 20'd0, 0);
      rst_n = 1'b1;
      // Unknown R-type func also traps
      instr(6'h00, 6'h3f, 1'b0);
      cyc("badfn F", S_F, cw_f, 0);
      cyc("badfn D", S_D, cw_d, 0);
      cyc("badfn T", S_T, 20'd0, 1);
      cyc("badfn T2", S_T, 20'd0, 1);
      rst_n = 1'b0;
      cyc("trap rst2", S_F, 20'd0, 0);
      rst_n = 1'b1;
      instr(6'h00, 6'h25, 1'b0);
      cyc("or F", S_F, cw_f, 0);
      cyc("or D", S_D, cw_d, 0);
      cyc("or E", S_E, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), 0);
      cyc("or W", S_W, cw_wb_rd, 0);

`ifdef MEM_WAIT_EN
      // FETCH stall: selects held, no IR/PC load until ready
      instr(6'h2b, 6'h00, 1'b0);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("stall F", S_F, cw(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2), 0);
      mem_ready = 1'b1;
      cyc("stall F rdy", S_F, cw_f, 0);
      cyc("stall sw D", S_D, cw_d, 0);
      cyc("stall sw E", S_E, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2), 0);
      mem_ready = 1'b0;
      cyc("stall sw M0", S_M, cw(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 0);
      cyc("stall sw M1", S_M, cw(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 0);
      mem_ready = 1'b1;
      cyc("stall sw M2", S_M, cw(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 0);
      // Reset in the middle of a FETCH stall
      mem_ready = 1'b0;
      cyc("midrst F", S_F, cw(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2), 0);
      rst_n = 1'b0;
      cyc("midrst R", S_F, 20'd0, 0);
      rst_n = 1'b1; mem_ready = 1'b1;
      cyc("midrst F2", S_F, cw_f, 0);
      cyc("midrst D", S_D, cw_d, 0);
`else
      // mem_ready is ignored without wait support
      instr(6'h23, 6'h00, 1'b0);
      mem_ready = 1'b0;
      cyc("nowait F", S_F, cw_f, 0);
      cyc("nowait D", S_D, cw_d, 0);
      cyc("nowait E", S_E, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2), 0);
      cyc("nowait M", S_M, cw(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0);
      cyc("nowait W", S_W, cw(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0), 0);
      cyc("nowait F2", S_F, cw_f, 0);
      mem_ready = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
